sram_like_bus_arbiter: RTL
==========================

// Module: sram_like_bus_arbiter
// PURPOSE
//  Shares one sram-like slave port (to the AXI bridge) between the core's inst and data sram-like masters.
//  Sits between mips_core_with_sram_like and the sram-like->AXI converter; one transaction in flight at a time.
//  Routes addr_ok/data_ok/rdata back to the owning master only; other master sees its handshakes held low.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (wdata/rdata)
// PORTS
//  clk              in   1    clock, all state on rising edge
//  rst              in   1    asynchronous, active-low reset
//  inst_req/inst_wr in   1/1  inst master request / write flag
//  inst_size        in   2    inst master size
//  inst_addr        in   AW   inst master address
//  inst_wdata       in   DW   inst master write data
//  inst_addr_ok     out  1    inst address accepted
//  inst_data_ok     out  1    inst transfer complete
//  inst_rdata       out  DW   inst read data
//  data_req/data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_*, data master
//  s_req/s_wr       out  1/1  slave request / write flag
//  s_size           out  2    slave size
//  s_addr           out  AW   slave address
//  s_wdata          out  DW   slave write data
//  s_addr_ok        in   1    slave address accepted
//  s_data_ok        in   1    slave transfer complete
//  s_rdata          in   DW   slave read data
//  busy             out  1    1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, owner=DATA, last=INST; s_req=0, all *_addr_ok/*_data_ok=0, busy=0, rdata outs=0 when not owner.
//  Masters hold req and payload stable until addr_ok (sram-like rule); arbiter relies on this.
//  FSM:
//   IDLE: grant=select(inst_req,data_req); s_* = granted master payload, s_req=granted req (combinational, 0-cycle).
//     s_addr_ok&s_data_ok same cycle -> forward both to granted master, stay IDLE.
//     s_addr_ok only -> latch owner, go WAIT_DATA.  req without addr_ok -> latch owner, go WAIT_ADDR.
//   WAIT_ADDR: grant locked to owner (no switching even if other req rises); s_req=owner req.
//     addr_ok&data_ok -> IDLE; addr_ok -> WAIT_DATA.
//   WAIT_DATA: s_req=0 (no second outstanding); on s_data_ok -> pulse owner *_data_ok, owner *_rdata=s_rdata, go IDLE.
//  Back-to-back: one IDLE cycle between transactions minimum (new grant evaluated in IDLE).
//  Non-owner *_addr_ok/*_data_ok always 0; *_rdata of non-owner = 0.
//  Simultaneous inst_req&data_req in IDLE: default fixed priority DATA wins (avoids core MEM-stage deadlock).
//  s_data_ok in IDLE/WAIT_ADDR without addr_ok: protocol violation, ignored (no forward).
//  Owner deasserting req in WAIT_ADDR: protocol violation; arbiter returns to IDLE next cycle.
//  Async reset mid-transaction: immediate IDLE, in-flight transfer dropped, all handshakes low.
// CONFIGURATION
//  SRAM_LIKE_ARB_RR_EN defined: round-robin on simultaneous requests; winner = master != last;
//   last updated to owner on every addr_ok.
//  Not defined: fixed priority, data over inst; last register not built.
// STRUCTURE
//  Package sram_like_arb_pkg: state localparams (IDLE=2'd0, WAIT_ADDR=2'd1, WAIT_DATA=2'd2),
//   owner encoding (OWN_INST=1'b0, OWN_DATA=1'b1), SIZE_* codes.
//  Sub-module arb_grant_sel: combinational grant from {inst_req,data_req,last}; RR/fixed chosen by macro.
//  Top: FSM + owner/last regs + payload/response muxes.
// TESTING
//  1 inst_req only, addr 0xBFC00000, s_addr_ok cycle 0, s_data_ok+rdata 0x3C1D8000 cycle 3 -> inst_data_ok pulse, inst_rdata=0x3C1D8000, data_* low.
//  2 inst_req & data_req same cycle, fixed prio -> data granted first, inst granted in IDLE after data_data_ok; with RR_EN two rounds alternate.
//  3 data write addr 0x80001000 wdata 0xDEADBEEF, s_addr_ok delayed 4 cycles while inst_req rises -> grant stays DATA, s_addr stable.
//  4 s_addr_ok & s_data_ok same cycle in IDLE -> both pulses to owner same cycle, state stays IDLE, busy=0.
//  5 rst low during WAIT_DATA -> busy=0, s_req=0 asynchronously; late s_data_ok after release not forwarded.
//  6 random 10k transactions vs. slave model with random latencies -> per-master in-order completion, no cross-routed rdata.

Source files
------------

// File: rtl/sram_like_arb_pkg.sv
// rtl/sram_like_arb_pkg.sv - shared types and codes for the sram-like bus arbiter
// Purpose: FSM state type, owner encoding and transfer size codes used by
//          sram_like_bus_arbiter and arb_grant_sel.
// Ports:   none (package).
package sram_like_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_grant_sel.sv
// rtl/arb_grant_sel.sv - combinational grant selection between inst and data masters
// Purpose: picks which master owns the slave port for a new transaction.
//          Macro SRAM_LIKE_ARB_RR_EN: round-robin on simultaneous requests
//          (winner is the master that did not win last). Undefined: data
//          always beats inst.
// Ports:   i_inst_req, i_data_req - master requests
//          i_last                 - owner of the most recently accepted address
//          o_grant                - selected owner (OWN_INST / OWN_DATA)
module arb_grant_sel
  import sram_like_arb_pkg::*;
(
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_last,
  output logic o_grant
);

`ifdef SRAM_LIKE_ARB_RR_EN
  always_comb begin
    o_grant = OWN_DATA;
    if (i_inst_req && i_data_req) begin
      o_grant = (i_last == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (i_inst_req) begin
      o_grant = OWN_INST;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_grant = OWN_DATA;
    if (i_inst_req && !i_data_req) begin
      o_grant = OWN_INST;
    end
  end
`endif

endmodule

// File: rtl/sram_like_bus_arbiter.sv
// rtl/sram_like_bus_arbiter.sv - shares one sram-like slave port between inst and data masters
// Purpose: one transaction in flight at a time; responses are routed only to
//          the owning master. Macro SRAM_LIKE_ARB_RR_EN enables round-robin
//          arbitration on simultaneous requests (default: data over inst).
// Ports:   clk, rst (async, active-low)
//          inst_* / data_* - master side: req, wr, size, addr, wdata in;
//                            addr_ok, data_ok, rdata out
//          s_*             - slave side: req, wr, size, addr, wdata out;
//                            addr_ok, data_ok, rdata in
//          busy            - high while a transaction is past IDLE
module sram_like_bus_arbiter
  import sram_like_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          s_req,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_addr_ok,
  input  logic          s_data_ok,
  input  logic [DW-1:0] s_rdata,
  output logic          busy
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_owner;
  logic       w_grant;
  logic       w_last;
  logic       w_sel;
  logic       w_sel_req;
  logic       w_addr_acc;
  logic       w_data_acc;

  arb_grant_sel u_grant_sel (
    .i_inst_req (inst_req),
    .i_data_req (data_req),
    .i_last     (w_last),
    .o_grant    (w_grant)
  );

  // A fresh grant is only taken in IDLE; afterwards the latched owner holds
  // the port so a late request from the other master cannot steal it.
  assign w_sel     = (r_state == IDLE) ? w_grant : r_owner;
  assign w_sel_req = (w_sel == OWN_DATA) ? data_req : inst_req;

  always_comb begin
    w_state_nxt = r_state;
    s_req       = 1'b0;
    w_addr_acc  = 1'b0;
    w_data_acc  = 1'b0;
    case (r_state)
      IDLE, WAIT_ADDR: begin
        if (w_sel_req) begin
          s_req = 1'b1;
          if (s_addr_ok) begin
            w_addr_acc = 1'b1;
            // data_ok only counts together with addr_ok before WAIT_DATA
            if (s_data_ok) begin
              w_data_acc  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WAIT_DATA;
            end
          end else begin
            w_state_nxt = WAIT_ADDR;
          end
        end else begin
          // Owner withdrew its request before addr_ok: abandon the attempt.
          w_state_nxt = IDLE;
        end
      end
      WAIT_DATA: begin
        if (s_data_ok) begin
          w_data_acc  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Handshakes are forced low for the whole reset window, not just at the edge.
    if (!rst) begin
      s_req      = 1'b0;
      w_addr_acc = 1'b0;
      w_data_acc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= OWN_DATA;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_sel_req) begin
        r_owner <= w_grant;
      end
    end
  end

`ifdef SRAM_LIKE_ARB_RR_EN
  logic r_last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= OWN_INST;
    end else if (w_addr_acc) begin
      r_last <= w_sel;
    end
  end
  assign w_last = r_last;
`else
  assign w_last = OWN_INST;
`endif

  assign s_wr    = (w_sel == OWN_DATA) ? data_wr    : inst_wr;
  assign s_size  = (w_sel == OWN_DATA) ? data_size  : inst_size;
  assign s_addr  = (w_sel == OWN_DATA) ? data_addr  : inst_addr;
  assign s_wdata = (w_sel == OWN_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_addr_acc && (w_sel == OWN_INST);
  assign data_addr_ok = w_addr_acc && (w_sel == OWN_DATA);
  assign inst_data_ok = w_data_acc && (w_sel == OWN_INST);
  assign data_data_ok = w_data_acc && (w_sel == OWN_DATA);

  // Read data is exposed only with the owner's data_ok, zero otherwise.
  assign inst_rdata = inst_data_ok ? s_rdata : '0;
  assign data_rdata = data_data_ok ? s_rdata : '0;

  assign busy = (r_state != IDLE);

endmodule
